// File: rtl/instr_fetch_pkg.sv
// Shared widths, reset constants and the fetch queue entry type for the fetch stage.
package instr_fetch_pkg;

    localparam int ADDRESS_BUS_WIDTH = 16;
    localparam int INSTRUCTION_WIDTH = 33;
    localparam int FETCH_Q_DEPTH     = 2;
    localparam int COUNT_WIDTH       = 2;

    localparam logic [ADDRESS_BUS_WIDTH-1:0] RESET_VECTOR = ADDRESS_BUS_WIDTH'(1024);

    // One decoded-ready item: the instruction word and the address it came from.
    typedef struct packed {
        logic [INSTRUCTION_WIDTH-1:0] instr;
        logic [ADDRESS_BUS_WIDTH-1:0] pc;
    } fetch_entry_t;

    // Sequential fetch address; wraps silently at the top of the address space.
    function automatic logic [ADDRESS_BUS_WIDTH-1:0] next_pc(input logic [ADDRESS_BUS_WIDTH-1:0] pc);
        return pc + ADDRESS_BUS_WIDTH'(1);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {instr, pc} between the RAM capture point and decode.
// slot0 is always the head; it keeps its old contents when the queue drains
// or is flushed, so the head outputs hold their last value while empty.
module fetch_queue
    import instr_fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  fetch_entry_t           push_entry,
    input  logic                   pop,
    input  logic                   flush,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   head_valid,
    output fetch_entry_t           head
);

    localparam logic [COUNT_WIDTH-1:0] EMPTY = COUNT_WIDTH'(0);
    localparam logic [COUNT_WIDTH-1:0] ONE   = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] FULL  = COUNT_WIDTH'(FETCH_Q_DEPTH);

    fetch_entry_t slot0;
    fetch_entry_t slot1;
    logic         pop_eff;
    logic         push_eff;

    assign pop_eff    = pop & (count != EMPTY);
    assign push_eff   = push & ((count != FULL) | pop_eff);
    assign head_valid = (count != EMPTY);
    assign head       = slot0;

    // Storage and occupancy update; flush empties the queue but leaves slot data untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= EMPTY;
        end else if (flush) begin
            count <= EMPTY;
        end else begin
            case ({push_eff, pop_eff})
                2'b10: begin
                    if (count == EMPTY) begin
                        slot0 <= push_entry;
                    end else begin
                        slot1 <= push_entry;
                    end
                    count <= count + ONE;
                end
                2'b01: begin
                    if (count == FULL) begin
                        slot0 <= slot1;
                    end
                    count <= count - ONE;
                end
                2'b11: begin
                    if (count == ONE) begin
                        slot0 <= push_entry;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_entry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The issue throttle upstream must make a push into a full queue impossible.
    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !flush && !pop_eff && count == FULL));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues reads to the instruction RAM,
// captures the word returned one clock later and queues it for decode.
// A redirect from execute reloads the PC and discards all wrong-path work.
module instr_fetch
    import instr_fetch_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    output logic [ADDRESS_BUS_WIDTH-1:0] imem_addr,
    output logic                         imem_read_not_write,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_data,
    input  logic                         fetch_en,
    input  logic                         redirect_valid,
    input  logic [ADDRESS_BUS_WIDTH-1:0] redirect_pc,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [INSTRUCTION_WIDTH-1:0] instr,
    output logic [ADDRESS_BUS_WIDTH-1:0] instr_pc
);

    logic [ADDRESS_BUS_WIDTH-1:0] fetch_pc;
    logic                         inflight;
    logic [ADDRESS_BUS_WIDTH-1:0] inflight_pc;
    logic [COUNT_WIDTH-1:0]       q_count;
    logic [2:0]                   occupancy;
    logic                         pop;
    logic                         issue;
    logic                         capture;
    fetch_entry_t                 capture_entry;
    fetch_entry_t                 head_entry;

    assign imem_addr           = fetch_pc;
    assign imem_read_not_write = 1'b1;

    // Occupancy counts queued words plus the one in flight, minus the head leaving
    // this edge; issuing only below 2 guarantees the returning word a free slot.
    assign pop       = instr_valid & instr_ready;
    assign occupancy = {1'b0, q_count} + {2'b00, inflight} - {2'b00, pop};
    assign issue     = fetch_en & ~redirect_valid & (occupancy < 3'd2);
    assign capture   = inflight & ~redirect_valid;

    assign capture_entry.instr = imem_data;
    assign capture_entry.pc    = inflight_pc;

    assign instr    = head_entry.instr;
    assign instr_pc = head_entry.pc;

    // PC and in-flight tracking; a redirect wins over issue and drops the returning word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_VECTOR;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
        end else if (issue) begin
            fetch_pc    <= next_pc(fetch_pc);
            inflight    <= 1'b1;
            inflight_pc <= fetch_pc;
        end else begin
            inflight <= 1'b0;
        end
    end

    fetch_queue u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (capture),
        .push_entry (capture_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .count      (q_count),
        .head_valid (instr_valid),
        .head       (head_entry)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a synchronous-read RAM model, a transaction-level
// reference of the fetch stream, directed scenarios and a randomized run.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic                         clk = 1'b0;
    logic                         rst = 1'b0;
    logic [ADDRESS_BUS_WIDTH-1:0] imem_addr;
    logic                         imem_read_not_write;
    logic [INSTRUCTION_WIDTH-1:0] imem_data = '0;
    logic                         fetch_en = 1'b0;
    logic                         redirect_valid = 1'b0;
    logic [ADDRESS_BUS_WIDTH-1:0] redirect_pc = '0;
    logic                         instr_valid;
    logic                         instr_ready = 1'b0;
    logic [INSTRUCTION_WIDTH-1:0] instr;
    logic [ADDRESS_BUS_WIDTH-1:0] instr_pc;

    logic [INSTRUCTION_WIDTH-1:0] mem [0:(1<<ADDRESS_BUS_WIDTH)-1];

    int n_vectors = 0;
    int n_miscompares = 0;

    fetch_entry_t                 mq[$];
    logic [ADDRESS_BUS_WIDTH-1:0] pend[$];
    logic [ADDRESS_BUS_WIDTH-1:0] m_pc;
    fetch_entry_t                 last_head;

    instr_fetch dut (
        .clk                 (clk),
        .rst                 (rst),
        .imem_addr           (imem_addr),
        .imem_read_not_write (imem_read_not_write),
        .imem_data           (imem_data),
        .fetch_en            (fetch_en),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .instr_valid         (instr_valid),
        .instr_ready         (instr_ready),
        .instr               (instr),
        .instr_pc            (instr_pc)
    );

    always #5 clk = ~clk;

    // Instruction RAM: word for the address sampled on an edge appears after that edge.
    always @(posedge clk) imem_data <= mem[imem_addr];

    task automatic compare(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        pend.delete();
        m_pc      = RESET_VECTOR;
        last_head = '0;
    endtask

    // Reference: words are read in program order, returned one edge later and
    // queued; at most two words may be queued or outstanding beyond the one leaving.
    task automatic model_step();
        bit                           pop_now;
        bit                           issue_now;
        int                           occ;
        logic [ADDRESS_BUS_WIDTH-1:0] p;
        fetch_entry_t                 e;
        if (rst) begin
            model_reset();
        end else if (redirect_valid) begin
            mq.delete();
            pend.delete();
            m_pc = redirect_pc;
        end else begin
            pop_now   = (mq.size() != 0) && instr_ready;
            occ       = mq.size() + pend.size() - (pop_now ? 1 : 0);
            issue_now = fetch_en && (occ < 2);
            if (pop_now) void'(mq.pop_front());
            if (pend.size() != 0) begin
                p       = pend.pop_front();
                e.instr = mem[p];
                e.pc    = p;
                mq.push_back(e);
            end
            if (issue_now) begin
                pend.push_back(m_pc);
                m_pc = m_pc + 1'b1;
            end
            if (mq.size() > 2) compare("model_queue_bound", 64'(mq.size()), 64'd2);
        end
    endtask

    // Compares every observable output against the reference after each edge.
    task automatic checkOutput();
        fetch_entry_t exp_head;
        logic         exp_valid;
        exp_valid = (mq.size() != 0);
        exp_head  = exp_valid ? mq[0] : last_head;
        compare("instr_valid", 64'(instr_valid), 64'(exp_valid));
        compare("imem_addr", 64'(imem_addr), 64'(m_pc));
        compare("imem_read_not_write", 64'(imem_read_not_write), 64'd1);
        compare("instr", 64'(instr), 64'(exp_head.instr));
        compare("instr_pc", 64'(instr_pc), 64'(exp_head.pc));
        last_head = exp_head;
    endtask

    // One clock of stimulus: drive inputs, advance model on the edge, check on the falling edge.
    task automatic applyStimulus(input logic fe, input logic rv,
                                 input logic [ADDRESS_BUS_WIDTH-1:0] rpc, input logic rdy);
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        @(posedge clk);
        model_step();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic expect_head(input string name, input logic v,
                               input logic [ADDRESS_BUS_WIDTH-1:0] pc, input logic [63:0] word);
        compare({name, "_valid"}, 64'(instr_valid), 64'(v));
        if (v) begin
            compare({name, "_pc"}, 64'(instr_pc), 64'(pc));
            compare({name, "_instr"}, 64'(instr), word);
        end
    endtask

    initial begin
        bit found;
        for (int i = 0; i < (1 << ADDRESS_BUS_WIDTH); i++) begin
            mem[i] = {16'(i) ^ 16'hA5C3, 1'b1, 16'(i)};
        end
        mem[1024] = 33'h021000000;
        mem[1025] = 33'h022000000;
        mem[1027] = 33'h052210000;
        mem[1029] = 33'h0E031FFFD;

        model_reset();
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput();
        expect_head("reset", 1'b0, '0, 64'd0);
        compare("reset_instr", 64'(instr), 64'd0);
        compare("reset_instr_pc", 64'(instr_pc), 64'd0);
        compare("reset_imem_addr", 64'(imem_addr), 64'd1024);
        rst = 1'b0;

        // First fetch after reset: two edges from issue to valid.
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        expect_head("first_edge1", 1'b0, '0, 64'd0);
        compare("first_edge1_addr", 64'(imem_addr), 64'd1025);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        expect_head("first_edge2", 1'b1, 16'd1024, 64'h021000000);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        expect_head("first_edge3", 1'b1, 16'd1025, 64'h022000000);
        compare("first_edge3_addr", 64'(imem_addr), 64'd1027);

        // Back-pressure: head held, PC frozen once the queue fills.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b0, '0, 1'b0);
            expect_head("stall", 1'b1, 16'd1025, 64'h022000000);
            compare("stall_addr", 64'(imem_addr), 64'd1027);
        end

        // Release and run to pc 1029 at the head.
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            if (instr_valid && instr_pc == 16'd1029) found = 1'b1;
            else applyStimulus(1'b1, 1'b0, '0, 1'b1);
        end
        compare("reach_pc_1029", 64'(found), 64'd1);
        compare("pc_1029_instr", 64'(instr), 64'h0E031FFFD);

        // Redirect back to 1027: 1030 is dropped, two empty cycles follow.
        applyStimulus(1'b1, 1'b1, 16'd1027, 1'b1);
        expect_head("redir_r0", 1'b0, '0, 64'd0);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        expect_head("redir_r1", 1'b0, '0, 64'd0);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        expect_head("redir_r2", 1'b1, 16'd1027, 64'h052210000);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        expect_head("redir_r3", 1'b1, 16'd1028, 64'(mem[1028]));

        // Fill the queue, then redirect while the head is being accepted.
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        expect_head("full", 1'b1, 16'd1028, 64'(mem[1028]));
        compare("full_addr", 64'(imem_addr), 64'd1030);
        applyStimulus(1'b1, 1'b1, 16'd1024, 1'b1);
        expect_head("full_redir_r0", 1'b0, '0, 64'd0);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        expect_head("full_redir_r2", 1'b1, 16'd1024, 64'h021000000);

        // Wrap at the top of the address space.
        applyStimulus(1'b1, 1'b1, 16'hFFFF, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        expect_head("wrap_r1", 1'b0, '0, 64'd0);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        expect_head("wrap_max", 1'b1, 16'hFFFF, 64'(mem[16'hFFFF]));
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        expect_head("wrap_zero", 1'b1, 16'h0000, 64'(mem[0]));
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        expect_head("wrap_one", 1'b1, 16'h0001, 64'(mem[1]));

        // Asynchronous reset between edges with a full queue.
        repeat (3) applyStimulus(1'b1, 1'b0, '0, 1'b0);
        expect_head("pre_async", 1'b1, 16'h0001, 64'(mem[1]));
        rst = 1'b1;
        #1;
        compare("async_valid", 64'(instr_valid), 64'd0);
        compare("async_instr", 64'(instr), 64'd0);
        compare("async_instr_pc", 64'(instr_pc), 64'd0);
        compare("async_addr", 64'(imem_addr), 64'd1024);
        model_reset();
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        expect_head("restart", 1'b1, 16'd1024, 64'h021000000);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 3000; k++) begin
            logic [ADDRESS_BUS_WIDTH-1:0] rpc;
            rpc = ($urandom_range(0, 1) == 0) ? ADDRESS_BUS_WIDTH'($urandom)
                                              : 16'hFFF8 + 16'($urandom_range(0, 7));
            rst = ($urandom_range(0, 399) == 0);
            applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
                          rpc, $urandom_range(0, 3) != 0);
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
